digit_serial_adder: RTL and testbench
=====================================

DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width in bits; SHALL be even and >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  operand set offered.
REQ-005 Port: in_ready  output  1  block able to accept operands.
REQ-006 Port: op_a  input  WIDTH  addend A.
REQ-007 Port: op_b  input  WIDTH  addend B.
REQ-008 Port: cin  input  1  carry-in.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer takes result.
REQ-011 Port: sum  output  WIDTH  (op_a + op_b + cin) mod 2^WIDTH.
REQ-012 Port: cout  output  1  carry-out of that addition.

Function
REQ-013 Block SHALL contain a 3-state FSM: IDLE, RUN, DONE.
REQ-014 in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is DONE; both registered-state decodes, no combinational path from inputs.
REQ-015 IDLE: on edge with in_valid=1, SHALL load op_a/op_b into operand shift registers, cin into carry register, clear digit counter, go to RUN; in_valid=0 holds IDLE.
REQ-016 RUN: each edge SHALL process one 2-bit digit from operand LSBs with carry register: s0 = a0^b0^c; c1 = maj(a0,b0,c); s1 = a1^b1^c1; c2 = maj(a1,b1,c1).
REQ-017 RUN: each edge SHALL shift operand registers right by 2, shift {s1,s0} into result register MSB end (result shifts right by 2), load c2 into carry register, increment counter.
REQ-018 After digit WIDTH/2 is processed, SHALL go to DONE; out_valid asserts WIDTH/2 edges after the accept edge (8 for WIDTH=16).
REQ-019 Counter SHALL be ceil(log2(WIDTH/2+1)) bits; it never wraps within an operation; the terminal compare occurs at count WIDTH/2-1.
REQ-020 DONE: sum = result register, cout = carry register; both SHALL stay stable while out_ready=0.
REQ-021 DONE with out_ready=1 SHALL go to IDLE on that edge; no same-cycle re-accept; minimum back-to-back period WIDTH/2+2 cycles.
REQ-022 in_valid, op_a, op_b, cin SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-023 Operand, result and carry registers SHALL NOT toggle in IDLE or DONE (low-power hold); sum/cout SHALL retain the last completed result in IDLE.
REQ-024 Counter SHALL hold in IDLE and DONE.
REQ-025 WIDTH=2 SHALL give a single RUN cycle with behaviour identical to one digit of REQ-016.

Reset
REQ-026 rst=1 SHALL, asynchronously and regardless of state (including mid-RUN), force state IDLE and clear operand regs, result reg, carry and counter to 0.
REQ-027 During and after reset: in_ready=1, out_valid=0, sum=0, cout=0; an aborted operation SHALL produce no result.
REQ-028 First accept SHALL occur on the first rising edge with rst=0 and in_valid=1.

Verification (WIDTH=16 unless noted)
REQ-029 Assert rst during RUN digit 4 -> out_valid=0, in_ready=1, sum=0x0000, cout=0 immediately, no result after release.
REQ-030 op_a=0xFFFF, op_b=0x0001, cin=0 -> sum=0x0000, cout=1, out_valid 8 edges after accept.
REQ-031 op_a=0x1234, op_b=0x4321, cin=1 -> sum=0x5556, cout=0.
REQ-032 out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> sum/cout unchanged, in_ready=0, new operands not taken.
REQ-033 in_valid=1 and out_ready=1 held, 3 operand sets -> results every 10 cycles, in order, each correct.
REQ-034 WIDTH=2: op_a=2'b11, op_b=2'b01, cin=1 -> sum=2'b01, cout=1, out_valid 1 edge after accept.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial (2 bits per cycle) adder with valid/ready handshakes on both sides.
// The result builds from the LSB digit upward and is held in DONE until it is taken.
module digit_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned DIGITS = WIDTH / 2;
    localparam int unsigned CW     = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             s0, s1, c1, c2;
    logic [WIDTH+1:0] r_shift;

    // One 2-bit ripple digit from the operand LSBs and the stored carry.
    always_comb begin
        s0      = a_q[0] ^ b_q[0] ^ c_q;
        c1      = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        s1      = a_q[1] ^ b_q[1] ^ c1;
        c2      = (a_q[1] & b_q[1]) | (a_q[1] & c1) | (b_q[1] & c1);
        r_shift = {s1, s0, r_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 2;
                b_d   = b_q >> 2;
                r_d   = r_shift[WIDTH+1:2];
                c_d   = c2;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = r_q;
    assign cout      = c_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: WIDTH=16 and WIDTH=2 instances against an arithmetic
// reference (a + b + cin), with handshake, latency, stall and reset-abort checks.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [15:0] op_a = '0, op_b = '0;
    logic        in_ready, out_valid, cout;
    logic [15:0] sum;

    logic        w2_in_valid = 1'b0, w2_out_ready = 1'b0, w2_cin = 1'b0;
    logic [1:0]  w2_op_a = '0, w2_op_b = '0;
    logic        w2_in_ready, w2_out_valid, w2_cout;
    logic [1:0]  w2_sum;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    digit_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    digit_serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(w2_in_valid), .in_ready(w2_in_ready),
        .op_a(w2_op_a), .op_b(w2_op_b), .cin(w2_cin), .out_valid(w2_out_valid),
        .out_ready(w2_out_ready), .sum(w2_sum), .cout(w2_cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full transaction on the WIDTH=16 instance: accept, latency, result, consume, hold.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] exp;
        int          edges;
        exp = 17'(a) + 17'(b) + 17'(c);
        @(negedge clk);
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1; op_a = a; op_b = b; cin = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_after_accept", 32'(in_ready), 32'd0);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!out_valid && edges < 40);
        check("latency", 32'(edges), 32'd8);
        check("sum", 32'(sum), 32'(exp[15:0]));
        check("cout", 32'(cout), 32'(exp[16]));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_take", {30'd0, in_ready, out_valid}, 32'd2);
        check("sum_held_idle", 32'(sum), 32'(exp[15:0]));
        check("cout_held_idle", 32'(cout), 32'(exp[16]));
    endtask

    task automatic run_op2(input logic [1:0] a, input logic [1:0] b, input logic c);
        logic [2:0] exp;
        int         edges;
        exp = 3'(a) + 3'(b) + 3'(c);
        @(negedge clk);
        w2_in_valid = 1'b1; w2_op_a = a; w2_op_b = b; w2_cin = c;
        @(posedge clk); #1;
        w2_in_valid = 1'b0;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!w2_out_valid && edges < 20);
        check("w2_latency", 32'(edges), 32'd1);
        check("w2_result", {29'd0, w2_cout, w2_sum}, {29'd0, exp});
        @(negedge clk);
        w2_out_ready = 1'b1;
        @(posedge clk); #1;
        w2_out_ready = 1'b0;
        check("w2_idle_after_take", 32'(w2_in_ready), 32'd1);
    endtask

    initial begin
        logic [16:0] exp;
        logic [15:0] ra, rb, held_sum;
        logic        rc, held_cout, seen;
        int          n;
        int unsigned t_prev;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {13'd0, in_ready, out_valid, cout, sum}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
        check("w2_reset_outputs", {27'd0, w2_in_ready, w2_out_valid, w2_cout, w2_sum}, {27'd0, 5'b10000});
        @(negedge clk);
        rst = 1'b0;

        // Carry through every digit, then mixed digits with carry-in
        run_op(16'hFFFF, 16'h0001, 1'b0);
        run_op(16'h1234, 16'h4321, 1'b1);
        run_op(16'hFFFF, 16'hFFFF, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom));
        end

        // Stall in DONE while new operands are offered
        @(negedge clk);
        in_valid = 1'b1; op_a = 16'h0F0F; op_b = 16'h00F1; cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        exp = 17'h0F0F + 17'h00F1;
        check("stall_first_sum", 32'(sum), 32'(exp[15:0]));
        held_sum = sum; held_cout = cout;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op_a = 16'($urandom); op_b = 16'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            check("stall_hold", {13'd0, in_ready, out_valid, cout, sum}, {13'd0, 1'b0, 1'b1, held_cout, held_sum});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall_release", {30'd0, in_ready, out_valid}, 32'd2);
        check("stall_sum_kept", 32'(sum), 32'(held_sum));

        // Back-to-back stream with in_valid and out_ready held high
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            exp = 17'(ra) + 17'(rb) + 17'(rc);
            op_a = ra; op_b = rb; cin = rc;
            n = 0;
            while (!in_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk); #1;
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!out_valid && n < 40);
            check("stream_sum", 32'(sum), 32'(exp[15:0]));
            check("stream_cout", 32'(cout), 32'(exp[16]));
            if (k > 0) check("stream_period", cyc - t_prev, 32'd10);
            t_prev = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stream_idle", 32'(in_ready), 32'd1);

        // Asynchronous reset in the middle of RUN (during digit 4)
        @(negedge clk);
        in_valid = 1'b1; op_a = 16'hABCD; op_b = 16'h1357; cin = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_outputs", {13'd0, in_ready, out_valid, cout, sum}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        run_op(16'h8000, 16'h8000, 1'b1);

        // WIDTH=2: named case, then every operand combination
        run_op2(2'b11, 2'b01, 1'b1);
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++)
                    run_op2(2'(a), 2'(b), 1'(c));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
